mcu_raster_streamer: RTL and testbench
======================================

# mcu_raster_streamer

Downstream of the MCU selection stage in the FPGA JPEG display path. Accepts one selected 8×8 MCU of 32-bit pixels per handshake and streams its pixels one per cycle in raster order. Each pixel is tagged with absolute frame coordinates for the framebuffer writer. The block tracks the MCU origin across the frame, wraps at line and frame end, and flags frame completion.

## Interface
Parameters:
- IMG_WIDTH, 640: frame width in pixels; multiple of 8.
- IMG_HEIGHT, 480: frame height in pixels; multiple of 8.
- COORD_W, 11: coordinate width; 2^COORD_W ≥ IMG_WIDTH and ≥ IMG_HEIGHT.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- sof  in  1: start-of-frame pulse; resets MCU origin to (0,0).
- mcu_in  in  [7:0][7:0][31:0]: MCU block, indexed [row][col].
- mcu_valid  in  1: mcu_in valid.
- mcu_ready  out  1: block accepts mcu_in this cycle.
- pix_data  out  32: current pixel.
- pix_x  out  COORD_W: absolute column of pix_data.
- pix_y  out  COORD_W: absolute row of pix_data.
- pix_valid  out  1: pixel outputs valid.
- pix_ready  in  1: downstream accepts pixel.
- frame_done  out  1: one-cycle pulse after the last pixel of the frame is accepted.

## Operation
- States are IDLE and STREAM. Reset enters IDLE.
- Internal registers:
  - blk: 64×32 buffer.
  - r, c: 3-bit in-block row and column.
  - ox, oy: MCU origin, COORD_W each, multiples of 8.
- mcu_ready = (state==IDLE) || (pix_valid && pix_ready && r==7 && c==7). It is combinational on pix_ready.
- Accept occurs when mcu_valid && mcu_ready:
  - Latch blk = mcu_in.
  - Set r=0, c=0.
  - Go to or stay in STREAM.
- In STREAM, the outputs are:
  - pix_data = blk[r][c]
  - pix_x = ox + c
  - pix_y = oy + r
  - pix_valid = 1
- Pixel handshake is pix_valid && pix_ready. On each handshake, advance c; when c wraps 7→0, advance r.
- On handshake of (r,c)=(7,7), advance the origin:
  - If ox+8 < IMG_WIDTH: ox += 8.
  - Otherwise: ox = 0 and oy += 8.
  - If additionally oy+8 ≥ IMG_HEIGHT: oy = 0 and frame_done pulses the next cycle.
- After the last pixel: with no simultaneous accept, go to IDLE and drop pix_valid. With a simultaneous accept, stay in STREAM with the new block at (0,0).
- sof handling:
  - In IDLE: sof sets ox=oy=0 at the next edge. If an accept happens in the same cycle, the new block uses origin (0,0).
  - In STREAM: sof is ignored.
- Coordinate adds are COORD_W-bit unsigned and cannot overflow under the parameter constraints.
- While pix_valid && !pix_ready, pix_data, pix_x and pix_y hold stable and no state advances.

## Timing
- Reset values: state IDLE, pix_valid 0, pix_data 0, pix_x 0, pix_y 0, ox=oy=0, frame_done 0. mcu_ready is 1 once rst_n is high, because the block is in IDLE.
- Latency: a block accepted at edge N presents pixel (0,0) with pix_valid=1 in the cycle after N.
- Throughput: 64 cycles per MCU with pix_ready held high. Back-to-back MCUs produce zero bubble cycles.
- frame_done is registered: high for exactly one cycle, the cycle after the final handshake.
- Reset asserted mid-stream:
  - All state returns to reset values immediately, without waiting for a clock edge.
  - The partial block is discarded.
  - No frame_done is generated.

## Test plan
- Reset: hold rst_n=0 with random inputs → pix_valid=0, pix_x=pix_y=0, frame_done=0. After release, mcu_ready=1.
- Single MCU, IMG_WIDTH=IMG_HEIGHT=16: send a checkerboard MCU (even col 32'hff00, odd col 32'h0000) with pix_ready=1.
  - Expect 64 consecutive pixels starting the cycle after accept.
  - pix_x cycles 0..7 within each row; pix_y runs 0..7.
  - pix_data alternates ff00/0000.
  - mcu_ready stays 0 until the last pixel's cycle.
- Back-to-back: 4 MCUs with mcu_valid held high.
  - No gaps between blocks.
  - Origins are (0,0), (8,0), (0,8), (8,8).
  - frame_done pulses once, the cycle after pixel (15,15).
  - The next MCU starts at (0,0).
- Backpressure: drop pix_ready for 5 cycles at pixel index 10, then toggle it randomly → outputs stay stable while stalled. All 64 pixels arrive exactly once, in order.
- Reset mid-stream at pixel 30 → pix_valid drops immediately. The next MCU streams from (0,0) with r=c=0.
- sof: stream 1 MCU (origin advances to (8,0)), pulse sof in IDLE → next MCU is at (0,0). A sof pulsed during STREAM does not change the following origin.

Source files
------------

// File: rtl/mcu_raster_streamer.sv
// mcu_raster_streamer
// Takes one 8x8 MCU of 32-bit pixels per handshake and streams it out one
// pixel per cycle in raster order. Each pixel is tagged with its absolute
// frame coordinates. The MCU origin walks across the frame left to right,
// then top to bottom, and frame_done pulses once the final pixel of the
// frame has been accepted.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holds its payload stable while valid && !ready. mcu_ready
// depends combinationally on pix_ready, so a new MCU is taken in the same
// cycle that the last pixel of the current one leaves.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   sof              start of frame; clears the MCU origin while idle
//   mcu_in           MCU block indexed [row][col]
//   mcu_valid/ready  MCU input handshake
//   pix_data         current pixel
//   pix_x, pix_y     absolute column / row of pix_data
//   pix_valid/ready  pixel output handshake
//   frame_done       one-cycle pulse after the last pixel of the frame
//   fsm_state        debug view of the FSM (0 = IDLE, 1 = STREAM)
module mcu_raster_streamer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sof,
  input  logic [7:0][7:0][31:0]    mcu_in,
  input  logic                     mcu_valid,
  output logic                     mcu_ready,
  output logic [31:0]              pix_data,
  output logic [COORD_W-1:0]       pix_x,
  output logic [COORD_W-1:0]       pix_y,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic                     frame_done,
  output logic                     fsm_state
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [COORD_W:0] W_LIM = (COORD_W+1)'(IMG_WIDTH);
  localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(IMG_HEIGHT);
  localparam logic [COORD_W:0] STEP  = (COORD_W+1)'(8);

  state_t                  state;
  logic [7:0][7:0][31:0]   blk;
  logic [2:0]              r;
  logic [2:0]              c;
  logic [COORD_W-1:0]      ox;
  logic [COORD_W-1:0]      oy;

  logic                    pix_fire;
  logic                    last_fire;
  logic                    accept;
  logic [COORD_W:0]        ox_step;
  logic [COORD_W:0]        oy_step;

  assign pix_valid = (state == STREAM);
  assign pix_fire  = pix_valid && pix_ready;
  assign last_fire = pix_fire && (r == 3'd7) && (c == 3'd7);
  assign mcu_ready = (state == IDLE) || last_fire;
  assign accept    = mcu_valid && mcu_ready;
  assign fsm_state = state;

  // One extra bit so the "past the frame edge" compare cannot wrap.
  assign ox_step = {1'b0, ox} + STEP;
  assign oy_step = {1'b0, oy} + STEP;

  // Outputs are decoded from registered state only, so they hold
  // automatically while the downstream stalls, and read zero when idle.
  assign pix_data = pix_valid ? blk[r][c] : 32'd0;
  assign pix_x    = pix_valid ? ox + COORD_W'(c) : '0;
  assign pix_y    = pix_valid ? oy + COORD_W'(r) : '0;

  // Pixel storage is data-only; its contents are masked whenever idle.
  always_ff @(posedge clk) begin
    if (accept) begin
      blk <= mcu_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= 3'd0;
      c          <= 3'd0;
      ox         <= '0;
      oy         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if ((state == IDLE) && sof) begin
        ox <= '0;
        oy <= '0;
      end

      if (pix_fire) begin
        c <= c + 3'd1;
        if (c == 3'd7) begin
          r <= r + 3'd1;
        end
      end

      // Origin moves once per MCU, on the handshake of pixel (7,7).
      if (last_fire) begin
        if (ox_step < W_LIM) begin
          ox <= ox_step[COORD_W-1:0];
        end else begin
          ox <= '0;
          if (oy_step >= H_LIM) begin
            oy         <= '0;
            frame_done <= 1'b1;
          end else begin
            oy <= oy_step[COORD_W-1:0];
          end
        end
      end

      if (accept) begin
        r     <= 3'd0;
        c     <= 3'd0;
        state <= STREAM;
      end else if (last_fire) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mcu_raster_streamer.sv
// Testbench for mcu_raster_streamer on a 16x16 frame (2x2 MCUs).
// Inputs change 1 time unit after the rising edge; the monitor samples on
// the falling edge. Expected pixels {data, x, y} are queued by the driver
// at the moment an MCU is accepted and popped by the monitor on each pixel
// handshake.
module tb_mcu_raster_streamer;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int CW = 11;
  localparam int EW = 32 + 2 * CW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  sof = 1'b0;
  logic [7:0][7:0][31:0] mcu_in = '0;
  logic                  mcu_valid = 1'b0;
  logic                  mcu_ready;
  logic [31:0]           pix_data;
  logic [CW-1:0]         pix_x;
  logic [CW-1:0]         pix_y;
  logic                  pix_valid;
  logic                  pix_ready = 1'b0;
  logic                  frame_done;
  logic                  fsm_state;

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  int ready_mode = 1;   // 0 = low, 1 = high, 2 = random
  int mox = 0;
  int moy = 0;
  int blk_id = 0;

  mcu_raster_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .mcu_in(mcu_in),
    .mcu_valid(mcu_valid), .mcu_ready(mcu_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_done(frame_done), .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  // pix_ready generator, updated just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+1. pattern 0: checkerboard, 1: tagged, 2: random.
  task automatic send_mcu(input int pattern, input bit keep);
    int n;
    bit ok;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (pattern)
          0:       mcu_in[r][c] = (c % 2 == 0) ? 32'hff00 : 32'h0000;
          1:       mcu_in[r][c] = {8'ha5, 8'(blk_id), 8'(r), 8'(c)};
          default: mcu_in[r][c] = $urandom;
        endcase
    blk_id++;
    mcu_valid = 1'b1;
    n = 0;
    ok = 0;
    while (!ok && n < 2000) begin
      @(negedge clk);
      #3;
      if (mcu_ready) ok = 1;
      n++;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL mcu_accept: mcu_ready never rose, got 0 expected 1");
    end else begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          exp_q.push_back({mcu_in[r][c], CW'(mox + c), CW'(moy + r)});
      if (mox + 8 < W) mox += 8;
      else begin
        mox = 0;
        if (moy + 8 >= H) moy = 0;
        else moy += 8;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) mcu_valid = 1'b0;
  endtask

  // Returns at negedge+2 once the monitor has counted `target` handshakes.
  task automatic wait_cnt(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (hs_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL wait_cnt: handshakes got %0d expected %0d", hs_cnt, target);
    end
  endtask

  // Drains the scoreboard, then resyncs to posedge+1.
  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: pixels left got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sof(input bit idle);
    sof = 1'b1;
    @(posedge clk);
    #1;
    sof = 1'b0;
    if (idle) begin
      mox = 0;
      moy = 0;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [31:0]   prev_data;
    logic [CW-1:0] prev_x, prev_y;
    bit stall_prev = 0;
    bit pend_fd = 0;
    bit new_fd;
    bit exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_fd = 0;
        stall_prev = 0;
      end else begin
        new_fd = 0;
        if (frame_done || pend_fd) check("frame_done", 64'(frame_done), 64'(pend_fd));
        check("pix_valid", 64'(pix_valid), 64'(exp_q.size() != 0));
        if (stall_prev && pix_valid) begin
          check("stall_data", 64'(pix_data), 64'(prev_data));
          check("stall_xy", 64'({pix_x, pix_y}), 64'({prev_x, prev_y}));
        end
        exp_rdy = 1'b1;
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          exp_rdy = pix_ready && (e[CW+2:CW] == 3'd7) && (e[2:0] == 3'd7);
        end
        check("mcu_ready", 64'(mcu_ready), 64'(exp_rdy));
        if (pix_valid && pix_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pixel", 64'({pix_data, pix_x, pix_y}), 64'(e));
          hs_cnt++;
          new_fd = (e[2*CW-1:CW] == CW'(W - 1)) && (e[CW-1:0] == CW'(H - 1));
        end
        stall_prev = pix_valid && !pix_ready;
        prev_data = pix_data;
        prev_x = pix_x;
        prev_y = pix_y;
        pend_fd = new_fd;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    // Reset with random inputs
    ready_mode = 2;
    repeat (4) begin
      @(posedge clk);
      #1;
      mcu_valid = 1'($urandom_range(0, 1));
      sof = 1'($urandom_range(0, 1));
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) mcu_in[r][c] = $urandom;
      @(negedge clk);
      check("rst_pix_valid", 64'(pix_valid), 64'd0);
      check("rst_pix_xy", 64'({pix_x, pix_y}), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_pix_data", 64'(pix_data), 64'd0);
    end
    @(posedge clk);
    #1;
    mcu_valid = 1'b0;
    sof = 1'b0;
    ready_mode = 1;
    rst_n = 1'b1;
    #1;
    check("post_rst_mcu_ready", 64'(mcu_ready), 64'd1);
    @(posedge clk);
    #1;

    // Single checkerboard MCU at (0,0), pix_ready high
    send_mcu(0, 0);
    wait_empty(200);

    // sof in idle returns the origin to (0,0), then four back-to-back MCUs
    // cover the whole frame, plus a fifth that wraps back to (0,0)
    pulse_sof(1);
    send_mcu(1, 1);
    send_mcu(1, 1);
    send_mcu(1, 1);
    send_mcu(1, 1);
    send_mcu(1, 0);
    wait_empty(200);

    // sof during STREAM is ignored: origin stays at (8,0)
    base = hs_cnt;
    send_mcu(1, 0);
    wait_cnt(base + 5, 100);
    @(posedge clk);
    #1;
    pulse_sof(0);
    send_mcu(1, 0);
    wait_empty(200);

    // Backpressure: stall at pixel 10 for 5 cycles, then random ready
    base = hs_cnt;
    send_mcu(2, 0);
    wait_cnt(base + 10, 100);
    ready_mode = 0;
    repeat (6) @(negedge clk);
    ready_mode = 2;
    wait_empty(1000);
    ready_mode = 1;

    // Reset in the middle of a block
    base = hs_cnt;
    send_mcu(2, 0);
    wait_cnt(base + 30, 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mox = 0;
    moy = 0;
    #1;
    check("midrst_pix_valid", 64'(pix_valid), 64'd0);
    check("midrst_pix_xy", 64'({pix_x, pix_y}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_mcu(1, 0);
    wait_empty(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
